// File: rtl/nes_pad_reader.sv
// NES-style serial gamepad reader: pulses latch, clocks out eight button bits
// and presents a registered active-high button vector with a valid pulse.
module nes_pad_reader #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned NUM_BUTTONS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       pad_present,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StShiftLo,
    StShiftHi,
    StDone
  } state_e;

  localparam logic [7:0] PhaseLast = 8'(CLK_DIV - 1);
  localparam logic [2:0] BitLast   = 3'(NUM_BUTTONS - 1);

  state_e     state_q, state_d;
  logic [7:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic       half_q, half_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] sync_q;
  logic       sample_en;

  logic       pad_latch_q, pad_clk_q, valid_q, busy_q, pad_present_q;
  logic [7:0] buttons_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_d     = bit_q;
    half_d    = half_q;
    sample_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLatch;
          phase_d = '0;
          half_d  = 1'b0;
          bit_d   = '0;
        end
      end
      StLatch: begin
        // Latch is held for two phase periods; bit 0 is sampled at its end.
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          if (half_q) begin
            sample_en = 1'b1;
            bit_d     = 3'd1;
            state_d   = StShiftLo;
          end else begin
            half_d = 1'b1;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StShiftLo: begin
        if (phase_q == PhaseLast) begin
          phase_d = '0;
          state_d = StShiftHi;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StShiftHi: begin
        if (phase_q == PhaseLast) begin
          phase_d   = '0;
          sample_en = 1'b1;
          if (bit_q == BitLast) begin
            state_d = StDone;
          end else begin
            bit_d   = bit_q + 3'd1;
            state_d = StShiftLo;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // First sample lands in bit 7 and is shifted down to bit 0 (button A).
  assign shift_d = sample_en ? {sync_q[1], shift_q[7:1]} : shift_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      bit_q         <= '0;
      half_q        <= 1'b0;
      shift_q       <= '0;
      sync_q        <= 2'b11;
      pad_latch_q   <= 1'b0;
      pad_clk_q     <= 1'b1;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      buttons_q     <= '0;
      pad_present_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      half_q      <= half_d;
      shift_q     <= shift_d;
      sync_q      <= {sync_q[0], pad_data};
      pad_latch_q <= (state_d == StLatch);
      pad_clk_q   <= (state_d != StShiftLo);
      valid_q     <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
      if (state_d == StDone) begin
        // An all-zero word means the line is stuck low: no pad attached.
        if (shift_d == 8'h00) begin
          buttons_q     <= '0;
          pad_present_q <= 1'b0;
        end else begin
          buttons_q     <= ~shift_d;
          pad_present_q <= 1'b1;
        end
      end
    end
  end

  assign pad_latch   = pad_latch_q;
  assign pad_clk     = pad_clk_q;
  assign valid       = valid_q;
  assign busy        = busy_q;
  assign buttons     = buttons_q;
  assign pad_present = pad_present_q;

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural NES pad shift register.
module tb_nes_pad_reader;

  logic       clk = 1'b0;
  logic       reset, start, pad_data;
  logic       pad_latch, pad_clk, pad_present, valid, busy;
  logic [7:0] buttons;

  int tests = 0;
  int fails = 0;

  // Pad model: word is active-low, bit 0 (A) presented first.
  logic [7:0] pad_word = 8'hFF;
  logic [7:0] pad_sr   = 8'hFF;
  logic       pad_clk_prev = 1'b1;
  logic       tie0 = 1'b0;

  always #5 clk = ~clk;

  nes_pad_reader #(.CLK_DIV(4), .NUM_BUTTONS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pad_data   (pad_data),
    .pad_latch  (pad_latch),
    .pad_clk    (pad_clk),
    .buttons    (buttons),
    .pad_present(pad_present),
    .valid      (valid),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (pad_latch) pad_sr <= pad_word;
    else if (pad_clk && !pad_clk_prev) pad_sr <= {1'b1, pad_sr[7:1]};
    pad_clk_prev <= pad_clk;
  end

  assign pad_data = tie0 ? 1'b0 : pad_sr[0];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issues start at cycle 0 and runs max_cyc cycles, re-pulsing start at s1..s3.
  task automatic do_read(input int max_cyc, input int s1, input int s2, input int s3,
                         output int vcnt, output int vfirst, output int vlast,
                         output logic [7:0] btn, output logic pres);
    vcnt = 0; vfirst = -1; vlast = -1; btn = 8'hxx; pres = 1'bx;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      if (valid) begin
        vcnt++;
        vlast = i;
        if (vfirst < 0) begin
          vfirst = i;
          btn    = buttons;
          pres   = pad_present;
        end
      end
      start = (i == s1) || (i == s2) || (i == s3);
      step;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] obs;
    reset = 1'b1; start = 1'b0;
    repeat (3) step;
    obs = {pad_latch, pad_clk, valid, busy, pad_present, |buttons};
    tests++;
    if (obs !== 6'b010000) begin
      fails++;
      $display("FAIL reset_state: got %b expected 010000", obs);
    end
    reset = 1'b0;
    step;
    obs = {pad_latch, pad_clk, valid, busy, pad_present, |buttons};
    tests++;
    if (obs !== 6'b010000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b expected 010000", obs);
    end
  endtask

  task automatic test_timing;
    logic exp_latch, exp_clk, exp_busy, exp_valid;
    pad_word = 8'hFF;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      exp_latch = (i >= 1) && (i <= 8);
      exp_clk   = !((i > 8) && (i <= 64) && (((i - 1) % 8) < 4));
      exp_busy  = (i <= 65);
      exp_valid = (i == 65);
      tests += 4;
      if (pad_latch !== exp_latch) begin
        fails++;
        $display("FAIL latch_wave c%0d: got %b expected %b", i, pad_latch, exp_latch);
      end
      if (pad_clk !== exp_clk) begin
        fails++;
        $display("FAIL clk_wave c%0d: got %b expected %b", i, pad_clk, exp_clk);
      end
      if (busy !== exp_busy) begin
        fails++;
        $display("FAIL busy_wave c%0d: got %b expected %b", i, busy, exp_busy);
      end
      if (valid !== exp_valid) begin
        fails++;
        $display("FAIL valid_wave c%0d: got %b expected %b", i, valid, exp_valid);
      end
      if (i == 65) begin
        tests++;
        if ({pad_present, buttons} !== 9'h100) begin
          fails++;
          $display("FAIL idle_pad_result: got %b/%h expected 1/00", pad_present, buttons);
        end
      end
      step;
    end
  endtask

  task automatic check_read(input string name, input logic [7:0] word, input logic t0,
                            input logic [7:0] exp_btn, input logic exp_pres);
    int vc, vf, vl;
    logic [7:0] b;
    logic p;
    pad_word = word;
    tie0     = t0;
    do_read(70, -1, -1, -1, vc, vf, vl, b, p);
    tests++;
    if (vc != 1 || vf != 65 || b !== exp_btn || p !== exp_pres) begin
      fails++;
      $display("FAIL %s: got n=%0d at %0d btn=%h pres=%b expected n=1 at 65 btn=%h pres=%b",
               name, vc, vf, b, p, exp_btn, exp_pres);
    end
  endtask

  task automatic test_buttons;
    check_read("a_right", 8'b0111_1110, 1'b0, 8'h81, 1'b1);
    check_read("up_start", 8'b1110_0111, 1'b0, 8'h18, 1'b1);
    tests++;
    if (buttons !== 8'h18) begin
      fails++;
      $display("FAIL buttons_hold: got %h expected 18", buttons);
    end
  endtask

  task automatic test_absent;
    check_read("tied_low", 8'hFF, 1'b1, 8'h00, 1'b0);
    check_read("reconnect", 8'hFF, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back;
    int vc, vf, vl;
    logic [7:0] b;
    logic p;
    pad_word = 8'b0111_1110;
    do_read(136, 10, 40, 65, vc, vf, vl, b, p);
    // Cycle 66 start comes from the loop below via a second call-free pulse.
    tests++;
    if (vc != 1 || vf != 65) begin
      fails++;
      $display("FAIL ignore_start: got n=%0d first=%0d expected n=1 at 65", vc, vf);
    end
    do_read(136, 10, 40, 65, vc, vf, vl, b, p);
    tests++;
    if (b !== 8'h81) begin
      fails++;
      $display("FAIL b2b_buttons: got %h expected 81", b);
    end
    // Start at 66 relative to a read: chain via s1=66.
    pad_word = 8'b1110_0111;
    do_read(140, 66, -1, -1, vc, vf, vl, b, p);
    tests++;
    if (vc != 2 || vf != 65 || vl != 131) begin
      fails++;
      $display("FAIL restart_66: got n=%0d first=%0d last=%0d expected 2/65/131", vc, vf, vl);
    end
    tests++;
    if (buttons !== 8'h18 || busy !== 1'b0) begin
      fails++;
      $display("FAIL restart_result: got btn=%h busy=%b expected 18/0", buttons, busy);
    end
  endtask

  task automatic test_reset_mid_read;
    int vseen;
    logic [4:0] obs;
    check_read("pre_abort", 8'b0111_1110, 1'b0, 8'h81, 1'b1);
    start = 1'b1;
    step;
    start = 1'b0;
    vseen = 0;
    for (int i = 1; i < 30; i++) begin
      if (valid) vseen++;
      step;
    end
    reset = 1'b1;
    step;
    reset = 1'b0;
    obs = {pad_latch, pad_clk, busy, pad_present, |buttons};
    tests++;
    if (obs !== 5'b01000) begin
      fails++;
      $display("FAIL abort_state: got %b expected 01000", obs);
    end
    for (int i = 0; i < 60; i++) begin
      if (valid) vseen++;
      step;
    end
    tests++;
    if (vseen != 0) begin
      fails++;
      $display("FAIL abort_no_valid: got %0d pulses expected 0", vseen);
    end
    check_read("after_abort", 8'b0111_1110, 1'b0, 8'h81, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset;
    test_timing;
    test_buttons;
    test_absent;
    test_back_to_back;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
